// File: rtl/fp_adder_nch_seq.sv
// fp_adder_nch_seq -- time-multiplexed fp32 channel summer.
//
// Sums a runtime-selected number of IEEE-754 single-precision channels
// (1..N_CH) with one shared FP_Adder, adding strictly in channel order
// (ch0+ch1, then +ch2, ...). A ready/valid handshake takes requests; the
// full channel vector is captured on accept so the producer is released
// immediately.
//
// Ports (fp_adder_nch_seq):
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   Data_In    N_CH packed fp32 channels, channel i at [32*i+31:32*i]
//   Num_Ch     channels to sum (saturates at N_CH), sampled on accept
//   RMode      rounding mode forwarded to FP_Adder, sampled on accept
//   Valid_In   request
//   In_Ready   block can accept (IDLE or DONE)
//   Data_Out   fp32 sum, held until the next result
//   Valid_Out  one-cycle result strobe
//   Busy       high while draining or summing
//
// Optional feature macro: FP_ADDER_NCH_RELU_EN clamps negative non-NaN
// results (including -0.0) to +0.0 on the way to Data_Out; the internal
// accumulator is never clamped.
//
// FP_Adder (also in this file): pipelined fp32 adder, latency LAT cycles,
// Mode=1 subtracts, RMode 0=nearest-even 1=toward zero 2=+inf 3=-inf.

module FP_Adder #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic [31:0] Data_A,
    input  logic [31:0] Data_B,
    input  logic        Mode,
    input  logic [1:0]  RMode,
    input  logic        Valid_In,
    output logic [31:0] Data_Out,
    output logic        Valid_Out
);
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] rm);
        logic [31:0] x, y, r;
        logic        sx, sub, inc, found, to_inf;
        logic [9:0]  ex, ey, e, d, sh, lz;
        logic [26:0] mx, my;
        logic [27:0] s;
        logic [24:0] mr;
        logic        a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        // x carries the larger magnitude, so its sign is the result sign
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        sx  = x[31];
        sub = x[31] ^ y[31];
        ex  = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey  = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        // 24-bit significand plus guard, round and sticky positions
        mx  = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my  = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d   = ex - ey;
        if (d >= 10'd27) my = {26'd0, |my};
        else             my = (my >> d) | {26'd0, |(my & ~({27{1'b1}} << d))};
        s = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
        e = ex;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // left-normalise, stopping at the subnormal exponent floor
            lz    = 10'd0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz = lz + 10'd1;
                end
            end
            sh = (lz < e - 10'd1) ? lz : e - 10'd1;
            s  = s << sh;
            e  = e - sh;
        end
        case (rm)
            2'd0:    inc = s[2] & (s[1] | s[0] | s[3]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = ~sx & (|s[2:0]);
            default: inc = sx & (|s[2:0]);
        endcase
        mr = {1'b0, s[26:3]} + {24'd0, inc};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            e  = e + 10'd1;
        end
        to_inf = (rm == 2'd0) || ((rm == 2'd2) && !sx) || ((rm == 2'd3) && sx);
        if (e >= 10'd255)
            r = to_inf ? {sx, 8'hFF, 23'd0} : {sx, 8'hFE, {23{1'b1}}};
        else
            r = {sx, mr[23] ? e[7:0] : 8'd0, mr[22:0]};
        // exact cancellation gives +0 except when rounding toward -inf
        if (s == 28'd0)
            r = {sub ? (rm == 2'd3) : sx, 31'd0};
        if (a_nan || b_nan || (a_inf && b_inf && sub)) r = 32'h7FC00000;
        else if (a_inf)                                r = a;
        else if (b_inf)                                r = b;
        return r;
    endfunction

    logic [31:0]    pipe_d [LAT];
    logic [LAT-1:0] pipe_v;

    // Result computed on entry, then delayed so Valid_Out trails Valid_In by LAT
    always_ff @(posedge clk) begin
        pipe_d[0] <= fp_add(Data_A, {Data_B[31] ^ Mode, Data_B[30:0]}, RMode);
        pipe_v[0] <= Valid_In;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end

    assign Data_Out  = pipe_d[LAT-1];
    assign Valid_Out = pipe_v[LAT-1];
endmodule

module fp_adder_nch_seq #(
    parameter  int N_CH    = 128,
    parameter  int ADD_LAT = 4,
    localparam int NCH_W   = $clog2(N_CH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*32-1:0] Data_In,
    input  logic [NCH_W-1:0]   Num_Ch,
    input  logic [1:0]         RMode,
    input  logic               Valid_In,
    output logic               In_Ready,
    output logic [31:0]        Data_Out,
    output logic               Valid_Out,
    output logic               Busy
);
    localparam int CNT_W = $clog2(ADD_LAT + 1);

    typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   drain_cnt;
    logic [N_CH*32-1:0] ch_buf;
    logic [NCH_W-1:0]   k_q, k_in, idx;
    logic [1:0]         rmode_q;
    logic [31:0]        acc, ch_b, add_out, data_out, first_ch;
    logic               add_valid, accept;

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FP_ADDER_NCH_RELU_EN
        if (v[31] && !((v[30:23] == 8'hFF) && (v[22:0] != 23'd0))) return 32'h0;
`endif
        return v;
    endfunction

    assign In_Ready  = (state == IDLE) || (state == DONE);
    assign Valid_Out = (state == DONE);
    assign Busy      = (state == DRAIN) || (state == ISSUE) || (state == WAIT);
    assign Data_Out  = data_out;
    assign accept    = Valid_In && In_Ready;
    assign k_in      = (Num_Ch > NCH_W'(N_CH)) ? NCH_W'(N_CH) : Num_Ch;
    assign first_ch  = (k_in == '0) ? 32'h0 : Data_In[31:0];

    // Operand B: the buffered channel selected by idx
    always_comb begin
        ch_b = 32'h0;
        for (int i = 0; i < N_CH; i++)
            if (idx == NCH_W'(i)) ch_b = ch_buf[32*i +: 32];
    end

    // Operands come from registers, so they stay stable for the whole WAIT
    FP_Adder #(.LAT(ADD_LAT)) u_add (
        .clk       (clk),
        .Data_A    (acc),
        .Data_B    (ch_b),
        .Mode      (1'b0),
        .RMode     (rmode_q),
        .Valid_In  (state == ISSUE),
        .Data_Out  (add_out),
        .Valid_Out (add_valid)
    );

    // Next-state logic; adder strobes outside WAIT are stale and ignored
    always_comb begin
        state_n = state;
        case (state)
            DRAIN:      if (drain_cnt <= CNT_W'(1)) state_n = IDLE;
            IDLE, DONE: if (accept)                 state_n = (k_in <= NCH_W'(1)) ? DONE : ISSUE;
                        else if (state == DONE)     state_n = IDLE;
            ISSUE:      state_n = WAIT;
            WAIT:       if (add_valid)              state_n = (idx == k_q - NCH_W'(1)) ? DONE : ISSUE;
            default:    state_n = DRAIN;
        endcase
    end

    // State and datapath registers; Data_Out only changes on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DRAIN;
            drain_cnt <= CNT_W'(ADD_LAT);
            ch_buf    <= '0;
            k_q       <= '0;
            idx       <= '0;
            rmode_q   <= 2'd0;
            acc       <= 32'h0;
            data_out  <= 32'h0;
        end else begin
            state <= state_n;
            case (state)
                DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - CNT_W'(1);
                IDLE, DONE: if (accept) begin
                    ch_buf  <= Data_In;
                    k_q     <= k_in;
                    rmode_q <= RMode;
                    acc     <= first_ch;
                    idx     <= NCH_W'(1);
                    if (k_in <= NCH_W'(1)) data_out <= relu(first_ch);
                end
                WAIT: if (add_valid) begin
                    acc <= add_out;
                    idx <= idx + NCH_W'(1);
                    if (idx == k_q - NCH_W'(1)) data_out <= relu(add_out);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_adder_nch_seq.sv
// Testbench for fp_adder_nch_seq (N_CH=8, ADD_LAT=4). Table-driven vectors
// feed a scoreboard holding expected sum and expected result cycle; a
// negedge monitor pops and compares on every Valid_Out. Hand-written
// sequences cover reset drain, busy-time requests, back-to-back accept and
// reset during a sum.
`timescale 1ns/1ps
module tb_fp_adder_nch_seq;
    localparam int N_CH    = 8;
    localparam int ADD_LAT = 4;
    localparam int NCH_W   = $clog2(N_CH + 1);
    localparam logic [31:0] ONE = 32'h3F800000;
    localparam logic [31:0] TWO = 32'h40000000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_CH*32-1:0] Data_In = '0;
    logic [NCH_W-1:0]   Num_Ch = '0;
    logic [1:0]         RMode = 2'd0;
    logic               Valid_In = 1'b0;
    logic               In_Ready, Valid_Out, Busy;
    logic [31:0]        Data_Out;

    fp_adder_nch_seq #(.N_CH(N_CH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst), .Data_In(Data_In), .Num_Ch(Num_Ch), .RMode(RMode),
        .Valid_In(Valid_In), .In_Ready(In_Ready), .Data_Out(Data_Out),
        .Valid_Out(Valid_Out), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t sb[$];

    typedef struct {
        int                 num;
        logic [1:0]         rm;
        logic [N_CH*32-1:0] d;
        logic [31:0]        raw;
        logic [31:0]        clamped;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [N_CH*32-1:0] chs(input logic [31:0] c0, input logic [31:0] c1 = 0,
        input logic [31:0] c2 = 0, input logic [31:0] c3 = 0, input logic [31:0] c4 = 0,
        input logic [31:0] c5 = 0, input logic [31:0] c6 = 0, input logic [31:0] c7 = 0);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic vec_t mkv(input int num, input logic [1:0] rm, input logic [N_CH*32-1:0] d,
                                 input logic [31:0] raw, input logic [31:0] clamped);
        vec_t v;
        v.num = num; v.rm = rm; v.d = d; v.raw = raw; v.clamped = clamped;
        return v;
    endfunction

    function automatic logic [31:0] pick(input vec_t v);
`ifdef FP_ADDER_NCH_RELU_EN
        return v.clamped;
`else
        return v.raw;
`endif
    endfunction

    function automatic int latency(input int num);
        int k;
        k = (num > N_CH) ? N_CH : num;
        return (k <= 1) ? 1 : 1 + (k - 1) * (ADD_LAT + 1);
    endfunction

    // Every result strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (Valid_Out) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_result: got Data_Out=%h at cycle %0d, expected no Valid_Out", Data_Out, cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("result_data", Data_Out, e.data);
                checkOutput("result_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; leaves Valid_In low at the following negedge
    task automatic applyStimulus(input int num, input logic [1:0] rm, input logic [N_CH*32-1:0] d,
                                 input logic [31:0] expv);
        int waited = 0;
        while (!In_Ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!In_Ready) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL ready_timeout: got In_Ready=0 after %0d cycles, expected 1", waited);
            return;
        end
        Num_Ch   = NCH_W'(num);
        RMode    = rm;
        Data_In  = d;
        Valid_In = 1'b1;
        sb.push_back('{expv, cyc + latency(num)});
        @(negedge clk);
        Valid_In = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (sb.size() != 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL result_timeout: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Called at the negedge where rst is released
    task automatic checkDrain();
        for (int i = 0; i < ADD_LAT; i++) begin
            checkOutput("drain_in_ready", 32'(In_Ready), 32'd0);
            checkOutput("drain_busy", 32'(Busy), 32'd1);
            checkOutput("drain_data_out", Data_Out, 32'h0);
            @(negedge clk);
        end
        checkOutput("post_drain_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("post_drain_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[15];
        vecs[0]  = mkv(4,  2'd0, chs(ONE, ONE, ONE, ONE, 32'h42C80000), 32'h40800000, 32'h40800000);
        vecs[1]  = mkv(1,  2'd0, chs(32'hC0000000, ONE), 32'hC0000000, 32'h00000000);
        vecs[2]  = mkv(0,  2'd0, chs(ONE, ONE), 32'h00000000, 32'h00000000);
        vecs[3]  = mkv(2,  2'd0, chs(32'hBF800000, 32'hC0000000), 32'hC0400000, 32'h00000000);
        vecs[4]  = mkv(3,  2'd0, chs(ONE, TWO, 32'h3F000000, ONE), 32'h40600000, 32'h40600000);
        vecs[5]  = mkv(2,  2'd0, chs(ONE, 32'hBF800000), 32'h00000000, 32'h00000000);
        vecs[6]  = mkv(8,  2'd0, chs(ONE, TWO, 32'h40400000, 32'h40800000, 32'h40A00000,
                                     32'h40C00000, 32'h40E00000, 32'h41000000), 32'h42100000, 32'h42100000);
        vecs[7]  = mkv(2,  2'd0, chs(ONE, 32'h33800000), 32'h3F800000, 32'h3F800000);
        vecs[8]  = mkv(2,  2'd2, chs(ONE, 32'h33800000), 32'h3F800001, 32'h3F800001);
        vecs[9]  = mkv(13, 2'd0, {N_CH{ONE}}, 32'h41000000, 32'h41000000);
        vecs[10] = mkv(2,  2'd0, chs(TWO, 32'hC0400000), 32'hBF800000, 32'h00000000);
        vecs[11] = mkv(2,  2'd0, chs(32'hFFC00000, ONE), 32'h7FC00000, 32'h7FC00000);
        vecs[12] = mkv(2,  2'd0, chs(32'h7F800000, ONE), 32'h7F800000, 32'h7F800000);
        vecs[13] = mkv(2,  2'd3, chs(ONE, 32'hBF800000), 32'h80000000, 32'h00000000);
        vecs[14] = mkv(1,  2'd0, chs(32'hFFC00000), 32'hFFC00000, 32'hFFC00000);

        // Reset values, then the drain window after release
        repeat (3) @(negedge clk);
        checkOutput("reset_valid_out", 32'(Valid_Out), 32'd0);
        checkOutput("reset_in_ready", 32'(In_Ready), 32'd0);
        checkOutput("reset_busy", 32'(Busy), 32'd1);
        rst = 1'b0;
        checkDrain();

        for (int i = 0; i < 15; i++)
            applyStimulus(vecs[i].num, vecs[i].rm, vecs[i].d, pick(vecs[i]));
        waitDrain();

        // A request pulsed while busy is dropped: exactly one result appears
        $display("[TB] busy-time request sequence");
        applyStimulus(13, 2'd0, {N_CH{ONE}}, 32'h41000000);
        repeat (2) @(negedge clk);
        checkOutput("busy_in_ready", 32'(In_Ready), 32'd0);
        checkOutput("busy_flag", 32'(Busy), 32'd1);
        Num_Ch   = NCH_W'(1);
        Data_In  = chs(32'h40400000);
        Valid_In = 1'b1;
        @(negedge clk);
        Valid_In = 1'b0;
        waitDrain();
        repeat (10) @(negedge clk);
        checkOutput("data_hold", Data_Out, 32'h41000000);

        // Second request accepted in the DONE cycle of the first
        $display("[TB] back-to-back sequence");
        applyStimulus(2, 2'd0, chs(ONE, ONE), 32'h40000000);
        Num_Ch   = NCH_W'(1);
        Data_In  = chs(32'h40400000);
        Valid_In = 1'b1;
        for (int w = 0; w < 50 && !In_Ready; w++) @(negedge clk);
        checkOutput("b2b_accept_in_done", 32'(Valid_Out), 32'd1);
        sb.push_back('{32'h40400000, cyc + 1});
        @(negedge clk);
        Valid_In = 1'b0;
        waitDrain();

        // Reset mid-sum: no result for the aborted request, clean restart
        $display("[TB] reset during WAIT sequence");
        Num_Ch   = NCH_W'(8);
        Data_In  = {N_CH{ONE}};
        Valid_In = 1'b1;
        @(negedge clk);
        Valid_In = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("mid_sum_busy", 32'(Busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_data_out", Data_Out, 32'h0);
        checkOutput("abort_in_ready", 32'(In_Ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        checkDrain();
        applyStimulus(2, 2'd0, chs(ONE, ONE), 32'h40000000);
        waitDrain();
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
